serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Sequencer that reuses one 1-bit full-adder cell to add two WIDTH-bit operands bit-serially, LSB first, over WIDTH clock cycles. The cell is two half-adder stages: sum = a ^ b ^ c, carry = (a & b) | (c & (a ^ b)). The block accepts an operand pair on a valid/ready input port and returns sum, carry-out and signed overflow on a valid/ready output port. It is the area-minimal arithmetic path for low-rate control datapaths; one operation is in flight at a time.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair and in_cin are valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  WIDTH  operand A, unsigned or two's complement.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer takes the result.
- out_sum  output  WIDTH  (in_a + in_b + in_cin) mod 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.
- out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  an operation is being computed (ADD state).

## Operation
- The FSM has three states: IDLE, ADD and DONE. The reset state is IDLE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid & in_ready, in_a and in_b load into shift registers, in_cin loads into the carry flop, the bit counter clears to 0 and the FSM goes to ADD.
  - Inputs are not sampled at any other time. They may change freely after acceptance.
- **ADD:**
  - in_ready = 0 and busy = 1.
  - Each cycle the cell adds operand bit 0 of A, bit 0 of B and the carry flop.
  - The resulting sum bit shifts into the MSB of the result register, which shifts right.
  - Both operand registers shift right, the carry flop takes the new carry, and the counter increments.
  - On the cycle the counter reaches WIDTH-1, the carry into the MSB is also saved for out_ovf.
  - After that cycle the FSM goes to DONE.
- **DONE:**
  - out_valid = 1; out_sum, out_cout and out_ovf are driven from registers and stay stable.
  - in_ready = 0; in_valid is ignored.
  - On out_ready = 1 the FSM goes to IDLE.
- out_sum, out_cout and out_ovf are forced to 0 whenever out_valid = 0. Partial results are never visible.
- Arithmetic is modulo 2^WIDTH. No saturation is applied.

## Timing
- **Reset (rst_n low, asynchronous):**
  - State is IDLE.
  - out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, busy = 0.
  - in_ready = 1; it is decoded from state.
  - All internal registers are cleared.
- **Reset deassertion:** release takes effect on the next rising clk edge. The block can accept an operation on the first edge after rst_n rises.
- **Reset mid-operation:** reset asserted in ADD or DONE aborts the operation immediately, with no output pulse. The result is discarded.
- **Latency:** acceptance at edge k puts the FSM in ADD for edges k+1 .. k+WIDTH. out_valid rises after edge k+WIDTH, which is WIDTH cycles after acceptance.
- **Result handshake:** a transfer occurs at an edge m where out_valid & out_ready. After edge m, out_valid = 0 and in_ready = 1; the earliest next acceptance is edge m+1.
- **Throughput:** maximum one operation per WIDTH+2 cycles with out_ready tied high.
- **Backpressure:** out_valid stays high until out_ready. It never drops without a transfer, and outputs do not change while waiting.
- **Input handshake:** in_ready does not depend combinationally on in_valid.
- **Combinational paths:** out_ready has no combinational path to any output.
- **Simultaneous events:** in_valid asserted during ADD or DONE is not accepted and not queued. The producer must hold in_valid until in_ready.

## Test plan
1. **Reset values:** rst_n low for 3 cycles, then hold it low while in_valid = 1 -> out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, busy = 0, in_ready = 1, and no acceptance occurs.
2. **Basic add and latency:** WIDTH = 8, in_a = 0x3C, in_b = 0x0F, in_cin = 0 accepted at edge k, out_ready = 1 -> out_valid rises exactly after edge k+8 with out_sum = 0x4B, cout = 0, ovf = 0. It is high for one cycle, then in_ready = 1.
3. **Carry and overflow corners (WIDTH = 8):**
   - 0xFF + 0x01 + 0 -> sum 0x00, cout 1, ovf 0.
   - 0x7F + 0x01 + 0 -> sum 0x80, cout 0, ovf 1.
   - 0x80 + 0x80 + 0 -> sum 0x00, cout 1, ovf 1.
   - 0xFF + 0xFF + 1 -> sum 0xFF, cout 1, ovf 0.
4. **Backpressure:** 0x12 + 0x34 with out_ready held low for 5 cycles after out_valid, and in_valid pulsed with new operands during the wait -> out_sum = 0x46 stable, in_ready = 0 throughout. The new operands are not accepted; the transfer happens on the edge where out_ready rises.
5. **Reset mid-operation:** rst_n pulsed low on the 3rd ADD cycle of 0xAA + 0x55 -> all outputs return to reset values at once and no out_valid follows. A subsequent 0x01 + 0x02 + 1 gives 0x04 after 8 cycles.
6. **Random regression:** 1000 random operands, random in_valid and out_ready at 50% duty, WIDTH = 8 and WIDTH = 2 -> every result matches the model a + b + cin (sum, cout, ovf) in order. Handshake rules hold and no result is lost or duplicated.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused LSB-first over WIDTH cycles.
// Latency: WIDTH cycles from input acceptance to out_valid; one operation in flight.
// Backpressure: result held stable in DONE until out_ready; in_ready low while busy.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready      result handshake (out_sum, out_cout, out_ovf)
//   busy                     high while bits are being added (ADD state)
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic             ovf_r;
  logic [CW-1:0]    cnt;

  logic load;
  logic shift;
  logic last;

  // The shared full-adder cell, built as two half-adder stages.
  logic ha_x;
  logic bit_sum;
  logic bit_carry;

  assign ha_x      = a_sr[0] ^ b_sr[0];
  assign bit_sum   = ha_x ^ carry;
  assign bit_carry = (a_sr[0] & b_sr[0]) | (carry & ha_x);

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= in_a;
      b_sr   <= in_b;
      sum_sr <= '0;
      carry  <= in_cin;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else if (shift) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= {bit_sum, sum_sr[WIDTH-1:1]};
      carry  <= bit_carry;
      cnt    <= cnt + CW'(1);
      // On the MSB cycle the carry flop still holds the carry into the MSB,
      // and bit_carry is the carry out of it.
      if (last) begin
        ovf_r <= carry ^ bit_carry;
      end
    end
  end

  // Outputs are gated so partial results never appear; the carry flop holds
  // the final carry out once the FSM is in DONE.
  assign out_sum  = out_valid ? sum_sr : '0;
  assign out_cout = out_valid & carry;
  assign out_ovf  = out_valid & ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=2.
// Both instances share the input stimulus; each has its own result scoreboard.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_cin;
  logic       out_ready;

  logic       in_ready8, out_valid8, out_cout8, out_ovf8, busy8;
  logic [7:0] out_sum8;
  logic       in_ready2, out_valid2, out_cout2, out_ovf2, busy2;
  logic [1:0] out_sum2;

  int total = 0;
  int bad   = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .out_sum   (out_sum8),
    .out_cout  (out_cout8),
    .out_ovf   (out_ovf8),
    .busy      (busy8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_a      (in_a[1:0]),
    .in_b      (in_b[1:0]),
    .in_cin    (in_cin),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_sum   (out_sum2),
    .out_cout  (out_cout2),
    .out_ovf   (out_ovf2),
    .busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] s;
    logic       ovf;
    s   = {1'b0, a} + {1'b0, b} + {8'b0, c};
    ovf = (a[7] == b[7]) && (s[7] != a[7]);
    return {ovf, s[8], s[7:0]};
  endfunction

  function automatic logic [3:0] model2(input logic [1:0] a, input logic [1:0] b, input logic c);
    logic [2:0] s;
    logic       ovf;
    s   = {1'b0, a} + {1'b0, b} + {2'b0, c};
    ovf = (a[1] == b[1]) && (s[1] != a[1]);
    return {ovf, s[2], s[1:0]};
  endfunction

  // One operation on the 8-bit instance with out_ready high.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo);
    int   lat;
    logic bz;
    out_ready = 1'b1;
    in_a      = a;
    in_b      = b;
    in_cin    = c;
    in_valid  = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready8), 32'd1);
    tick;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_cin   = ~c;
    lat = 0;
    bz  = 1'b1;
    while (!out_valid8 && lat < 40) begin
      if (!busy8 || in_ready8) bz = 1'b0;
      tick;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_busy_in_add"}, 32'(bz), 32'd1);
    chk({tag, "_sum"}, 32'(out_sum8), 32'(es));
    chk({tag, "_cout"}, 32'(out_cout8), 32'(ec));
    chk({tag, "_ovf"}, 32'(out_ovf8), 32'(eo));
    tick;
    chk({tag, "_valid_drop"}, 32'(out_valid8), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready8), 32'd1);
  endtask

  logic [9:0] q8[$];
  logic [3:0] q2[$];

  initial begin
    int         lat;
    logic       seen;
    int         n8;
    int         cyc;
    logic       pv8, pr8, pv2, pr2;
    logic [9:0] pres8;
    logic [3:0] pres2;
    logic [9:0] e8;
    logic [3:0] e2;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;

    // Reset values, with in_valid asserted during reset.
    repeat (3) tick;
    in_valid = 1'b1;
    in_a     = 8'h5A;
    in_b     = 8'h33;
    tick;
    tick;
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_out_sum", 32'(out_sum8), 32'd0);
    chk("rst_out_cout", 32'(out_cout8), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_in_ready", 32'(in_ready8), 32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick;
    chk("rst_no_accept", 32'(busy8), 32'd0);

    // Basic add and carry/overflow corners.
    do_op("basic", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
    do_op("c_ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("c_7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("c_8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    do_op("c_ffff1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Backpressure with new operands offered while the result waits.
    out_ready = 1'b0;
    in_a      = 8'h12;
    in_b      = 8'h34;
    in_cin    = 1'b0;
    in_valid  = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      tick;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_a     = 8'hEE;
      in_b     = 8'h77;
      chk("bp_valid", 32'(out_valid8), 32'd1);
      chk("bp_sum", 32'(out_sum8), 32'h46);
      chk("bp_in_ready", 32'(in_ready8), 32'd0);
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_sum_last", 32'(out_sum8), 32'h46);
    tick;
    chk("bp_xfer_valid", 32'(out_valid8), 32'd0);
    chk("bp_xfer_ready", 32'(in_ready8), 32'd1);
    chk("bp_not_queued", 32'(busy8), 32'd0);

    // Reset in the middle of an addition.
    in_a     = 8'hAA;
    in_b     = 8'h55;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready8), 32'd1);
    chk("mid_rst_valid", 32'(out_valid8), 32'd0);
    chk("mid_rst_sum", 32'(out_sum8), 32'd0);
    tick;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      tick;
      if (out_valid8) seen = 1'b1;
    end
    chk("mid_rst_no_pulse", 32'(seen), 32'd0);
    do_op("post_rst", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);

    // Random regression on both widths with a scoreboard each.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n8  = 0;
    cyc = 0;
    pv8 = 1'b0; pr8 = 1'b0; pv2 = 1'b0; pr2 = 1'b0;
    pres8 = '0; pres2 = '0;
    while (cyc < 40000 && (n8 < 1000 || q8.size() != 0 || q2.size() != 0 || out_valid2)) begin
      if (pv8 && !pr8)
        chk("r8_hold", 32'({out_valid8, out_ovf8, out_cout8, out_sum8}), 32'({1'b1, pres8}));
      if (pv2 && !pr2)
        chk("r2_hold", 32'({out_valid2, out_ovf2, out_cout2, out_sum2}), 32'({1'b1, pres2}));
      if (n8 < 1000) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      in_a   = 8'($urandom);
      in_b   = 8'($urandom);
      in_cin = 1'($urandom_range(0, 1));
      if (in_valid && in_ready8) begin
        q8.push_back(model8(in_a, in_b, in_cin));
        n8++;
      end
      if (in_valid && in_ready2) q2.push_back(model2(in_a[1:0], in_b[1:0], in_cin));
      if (out_valid8 && out_ready) begin
        if (q8.size() == 0) chk("r8_extra", 32'd1, 32'd0);
        else begin
          e8 = q8.pop_front();
          chk("r8_result", 32'({out_ovf8, out_cout8, out_sum8}), 32'(e8));
        end
      end
      if (out_valid2 && out_ready) begin
        if (q2.size() == 0) chk("r2_extra", 32'd1, 32'd0);
        else begin
          e2 = q2.pop_front();
          chk("r2_result", 32'({out_ovf2, out_cout2, out_sum2}), 32'(e2));
        end
      end
      pv8   = out_valid8;
      pr8   = out_ready;
      pres8 = {out_ovf8, out_cout8, out_sum8};
      pv2   = out_valid2;
      pr2   = out_ready;
      pres2 = {out_ovf2, out_cout2, out_sum2};
      tick;
      cyc++;
    end
    chk("r8_count", 32'(n8 >= 1000), 32'd1);
    chk("r8_drained", 32'(q8.size()), 32'd0);
    chk("r2_drained", 32'(q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
